// File: rtl/rv32_data_port_arbiter.sv
// rv32_data_port_arbiter
//
// Shares the single data port (port B) of rv32_main_memory between two requesters:
//   M0 - core load/store unit
//   M1 - DMA/debug loader
// Arbitration is round-robin. M1 may lock the port for a bounded burst of at most MAX_HOLD
// grants while M0 is waiting. One request is accepted per cycle. Each 1-cycle-latency BRAM
// response is routed back to the requester that issued it.
//
// Ports:
//   clk_i, reset_i           clock; synchronous active-high reset
//   m0_req_i/m0_valid_i      M0 request and valid
//   m0_ready_o               M0 request accepted this cycle
//   m0_rvalid_o/rdata/err    M0 response (load data or store ack; err = out of range)
//   m1_*                     same for M1, plus m1_lock_i to hold the grant
//   mem_req_o                to memory data_request
//   mem_ready_i              memory data_ready (address in range, combinational)
//   mem_rdata_i              memory read data, valid one cycle after the request
//
// Optional feature macro: RV32_MEM_ARB_PERF_EN
//   Adds the perf_m0_grants_o, perf_m1_grants_o and perf_conflicts_o counters.

package rv32_mem_pkg;
    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef struct packed {
        rv32_word addr;
        rv32_word data;
        mem_op_e  op;
    } memory_request_t;
endpackage

module rv32_data_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  memory_request_t m0_req_i,
    input  logic            m0_valid_i,
    output logic            m0_ready_o,
    output logic            m0_rvalid_o,
    output logic [31:0]     m0_rdata_o,
    output logic            m0_err_o,
    input  memory_request_t m1_req_i,
    input  logic            m1_valid_i,
    input  logic            m1_lock_i,
    output logic            m1_ready_o,
    output logic            m1_rvalid_o,
    output logic [31:0]     m1_rdata_o,
    output logic            m1_err_o,
    output memory_request_t mem_req_o,
    input  logic            mem_ready_i,
    input  logic [31:0]     mem_rdata_i
`ifdef RV32_MEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_m0_grants_o,
    output logic [31:0]     perf_m1_grants_o,
    output logic [31:0]     perf_conflicts_o
`endif
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

    typedef enum logic {
        OwnerM0 = 1'b0,
        OwnerM1 = 1'b1
    } owner_e;

    owner_e           last_grant_q, last_grant_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             r_valid_q;
    owner_e           r_owner_q;
    logic             r_err_q;

    logic             locked;
    logic             gnt_m0, gnt_m1, any_gnt;
    logic [31:0]      resp_data;

    // Grant decision. Nothing is accepted while reset is asserted.
    always_comb begin
        locked = (last_grant_q == OwnerM1) && m1_lock_i && (hold_cnt_q < HoldMax);
        gnt_m0 = 1'b0;
        gnt_m1 = 1'b0;
        if (!reset_i) begin
            if (m0_valid_i && m1_valid_i) begin
                // Tie: M1 keeps the port while locked, otherwise alternate.
                if (locked || (last_grant_q == OwnerM0)) begin
                    gnt_m1 = 1'b1;
                end else begin
                    gnt_m0 = 1'b1;
                end
            end else begin
                gnt_m0 = m0_valid_i;
                gnt_m1 = m1_valid_i;
            end
        end
    end

    assign any_gnt    = gnt_m0 || gnt_m1;
    assign m0_ready_o = gnt_m0;
    assign m1_ready_o = gnt_m1;

    // Memory request: out-of-range accesses keep their address but become NOPs so that no
    // write can land in memory.
    always_comb begin
        mem_req_o = '0;
        if (gnt_m0) begin
            mem_req_o = m0_req_i;
        end else if (gnt_m1) begin
            mem_req_o = m1_req_i;
        end
        if (!mem_ready_i) begin
            mem_req_o.op = MEM_NOP;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_m0) begin
            last_grant_d = OwnerM0;
        end else if (gnt_m1) begin
            last_grant_d = OwnerM1;
        end
    end

    // Counts M1 lock grants that made M0 wait; saturates so M0 wins the next tie.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (gnt_m0 || !m1_lock_i) begin
            hold_cnt_d = '0;
        end else if (gnt_m1 && m0_valid_i && (hold_cnt_q != HoldMax)) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= OwnerM1;
            hold_cnt_q   <= '0;
            r_valid_q    <= 1'b0;
            r_owner_q    <= OwnerM0;
            r_err_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            r_valid_q    <= any_gnt;
            if (any_gnt) begin
                r_owner_q <= gnt_m1 ? OwnerM1 : OwnerM0;
                r_err_q   <= !mem_ready_i;
            end
        end
    end

    // Response routing; the non-owner sees all zeros.
    assign resp_data   = r_err_q ? 32'd0 : mem_rdata_i;
    assign m0_rvalid_o = r_valid_q && (r_owner_q == OwnerM0);
    assign m1_rvalid_o = r_valid_q && (r_owner_q == OwnerM1);
    assign m0_err_o    = m0_rvalid_o && r_err_q;
    assign m1_err_o    = m1_rvalid_o && r_err_q;
    assign m0_rdata_o  = m0_rvalid_o ? resp_data : 32'd0;
    assign m1_rdata_o  = m1_rvalid_o ? resp_data : 32'd0;

`ifdef RV32_MEM_ARB_PERF_EN
    logic [31:0] perf_m0_q, perf_m1_q, perf_conf_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_m0_q   <= '0;
            perf_m1_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            if (gnt_m0) begin
                perf_m0_q <= perf_m0_q + 32'd1;
            end
            if (gnt_m1) begin
                perf_m1_q <= perf_m1_q + 32'd1;
            end
            if (m0_valid_i && m1_valid_i) begin
                perf_conf_q <= perf_conf_q + 32'd1;
            end
        end
    end

    assign perf_m0_grants_o = perf_m0_q;
    assign perf_m1_grants_o = perf_m1_q;
    assign perf_conflicts_o = perf_conf_q;
`endif

endmodule

// File: tb/tb_rv32_data_port_arbiter.sv
// tb_rv32_data_port_arbiter
//
// Self-checking bench for rv32_data_port_arbiter. A behavioural model (grant rule, hold counter,
// pending-response record and a shadow memory) predicts every output on every cycle. Directed
// sequences pin that model with literal expectations. A long randomized phase follows.
// Set RV32_MEM_ARB_PERF_EN to also exercise the performance counters.

module tb_rv32_data_port_arbiter;
    import rv32_mem_pkg::*;

    localparam int MaxHold  = 8;
    localparam int NumWords = 64;
    localparam int MemBytes = NumWords * 4;

    logic            clk = 1'b0;
    logic            reset;
    memory_request_t m0_req, m1_req, mem_req;
    logic            m0_valid, m1_valid, m1_lock;
    logic            m0_ready, m0_rvalid, m0_err;
    logic            m1_ready, m1_rvalid, m1_err;
    logic [31:0]     m0_rdata, m1_rdata;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
`ifdef RV32_MEM_ARB_PERF_EN
    logic [31:0]     perf_m0_grants, perf_m1_grants, perf_conflicts;
`endif

    always #5 clk = ~clk;

    rv32_data_port_arbiter #(
        .MAX_HOLD(MaxHold)
    ) u_dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .m0_req_i    (m0_req),
        .m0_valid_i  (m0_valid),
        .m0_ready_o  (m0_ready),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m0_err_o    (m0_err),
        .m1_req_i    (m1_req),
        .m1_valid_i  (m1_valid),
        .m1_lock_i   (m1_lock),
        .m1_ready_o  (m1_ready),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .m1_err_o    (m1_err),
        .mem_req_o   (mem_req),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata)
`ifdef RV32_MEM_ARB_PERF_EN
        ,
        .perf_m0_grants_o (perf_m0_grants),
        .perf_m1_grants_o (perf_m1_grants),
        .perf_conflicts_o (perf_conflicts)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Environment BRAM: ignores upper address bits, so an unsuppressed out-of-range store would
    // corrupt an aliased word.
    logic [31:0] env_mem [NumWords];
    // Reference memory: only in-range stores land here.
    logic [31:0] ref_mem [NumWords];

    // Model state
    int          mdl_last;
    int          mdl_hold;
    bit          mdl_pv;
    int          mdl_pown;
    bit          mdl_perr;
    logic [31:0] mdl_pdata;
    logic [31:0] mdl_pm0, mdl_pm1, mdl_pconf;

    // Values sampled from the DUT in the last step
    logic        s_m0_ready, s_m1_ready, s_m0_rvalid, s_m1_rvalid, s_m0_err, s_m1_err;
    logic [31:0] s_m0_rdata, s_m1_rdata;
    mem_op_e     s_mem_op;
    logic [31:0] s_perf_m0, s_perf_m1, s_perf_conf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] off, input mem_op_e op);
        logic [31:0] r;
        r = old;
        case (op)
            MEM_SB:  r[8*off +: 8] = d[7:0];
            MEM_SH:  r[16*off[1] +: 16] = d[15:0];
            MEM_SW:  r = d;
            default: r = old;
        endcase
        return r;
    endfunction

    function automatic memory_request_t mk(input logic [31:0] a, input logic [31:0] d,
                                           input mem_op_e op);
        memory_request_t r;
        r.addr = a;
        r.data = d;
        r.op   = op;
        return r;
    endfunction

    function automatic memory_request_t rand_req();
        logic [31:0] a;
        if ($urandom_range(9, 0) == 0) begin
            a = 32'(MemBytes) + 32'($urandom_range(63, 0) * 4);
        end else begin
            a = 32'($urandom_range(NumWords - 1, 0) * 4 + $urandom_range(3, 0));
        end
        return mk(a, $urandom, mem_op_e'(4'($urandom_range(8, 1))));
    endfunction

    // One clock cycle: drive, predict, compare, then advance environment and model past the edge.
    task automatic step(input bit rst, input bit v0, input memory_request_t r0, input bit v1,
                        input memory_request_t r1, input bit lock, output int g);
        memory_request_t greq, ereq, sreq;
        bit              inr;
        bit              e0v, e1v;
        @(negedge clk);
        reset    = rst;
        m0_valid = v0;
        m0_req   = r0;
        m1_valid = v1;
        m1_req   = r1;
        m1_lock  = lock;
        #1;
        mem_ready = (mem_req.addr < 32'(MemBytes));
        #2;

        g = -1;
        if (!rst) begin
            if (v0 && v1) begin
                if (mdl_last == 1 && lock && mdl_hold < MaxHold) g = 1;
                else g = 1 - mdl_last;
            end else if (v0) begin
                g = 0;
            end else if (v1) begin
                g = 1;
            end
        end
        greq = (g == 0) ? r0 : r1;
        inr  = greq.addr < 32'(MemBytes);
        ereq = '0;
        if (g >= 0) begin
            ereq = greq;
            if (!inr) ereq.op = MEM_NOP;
        end
        e0v = mdl_pv && mdl_pown == 0;
        e1v = mdl_pv && mdl_pown == 1;

        s_m0_ready  = m0_ready;
        s_m1_ready  = m1_ready;
        s_m0_rvalid = m0_rvalid;
        s_m1_rvalid = m1_rvalid;
        s_m0_err    = m0_err;
        s_m1_err    = m1_err;
        s_m0_rdata  = m0_rdata;
        s_m1_rdata  = m1_rdata;
        s_mem_op    = mem_req.op;
        sreq        = mem_req;
`ifdef RV32_MEM_ARB_PERF_EN
        s_perf_m0   = perf_m0_grants;
        s_perf_m1   = perf_m1_grants;
        s_perf_conf = perf_conflicts;
`endif

        if (chk_en) begin
            chk("m0_ready", 32'(s_m0_ready), 32'(g == 0));
            chk("m1_ready", 32'(s_m1_ready), 32'(g == 1));
            chk("mem_addr", sreq.addr, ereq.addr);
            chk("mem_data", sreq.data, ereq.data);
            chk("mem_op", 32'(sreq.op), 32'(ereq.op));
            chk("m0_rvalid", 32'(s_m0_rvalid), 32'(e0v));
            chk("m1_rvalid", 32'(s_m1_rvalid), 32'(e1v));
            chk("m0_err", 32'(s_m0_err), 32'(e0v && mdl_perr));
            chk("m1_err", 32'(s_m1_err), 32'(e1v && mdl_perr));
            chk("m0_rdata", s_m0_rdata, (e0v && !mdl_perr) ? mdl_pdata : 32'd0);
            chk("m1_rdata", s_m1_rdata, (e1v && !mdl_perr) ? mdl_pdata : 32'd0);
`ifdef RV32_MEM_ARB_PERF_EN
            chk("perf_m0", s_perf_m0, mdl_pm0);
            chk("perf_m1", s_perf_m1, mdl_pm1);
            chk("perf_conf", s_perf_conf, mdl_pconf);
`endif
        end

        @(posedge clk);
        // Environment BRAM, read-before-write.
        mem_rdata = env_mem[sreq.addr[7:2]];
        if (is_store(sreq.op)) begin
            env_mem[sreq.addr[7:2]] = merge(env_mem[sreq.addr[7:2]], sreq.data,
                                            sreq.addr[1:0], sreq.op);
        end

        if (rst) begin
            mdl_last  = 1;
            mdl_hold  = 0;
            mdl_pv    = 1'b0;
            mdl_pm0   = '0;
            mdl_pm1   = '0;
            mdl_pconf = '0;
        end else begin
            if (v0 && v1) mdl_pconf = mdl_pconf + 32'd1;
            if (g == 0) mdl_pm0 = mdl_pm0 + 32'd1;
            if (g == 1) mdl_pm1 = mdl_pm1 + 32'd1;
            mdl_pv = (g >= 0);
            if (g >= 0) begin
                mdl_pown  = g;
                mdl_perr  = !inr;
                mdl_pdata = inr ? ref_mem[greq.addr[7:2]] : 32'd0;
                if (inr && is_store(greq.op)) begin
                    ref_mem[greq.addr[7:2]] = merge(ref_mem[greq.addr[7:2]], greq.data,
                                                    greq.addr[1:0], greq.op);
                end
                mdl_last = g;
            end
            if (g == 0 || !lock) mdl_hold = 0;
            else if (g == 1 && v0 && mdl_hold < MaxHold) mdl_hold++;
        end
    endtask

    initial begin
        memory_request_t nil, a, b, p0r, p1r;
        int  g;
        bit  p0v, p1v, lk, rst;
        bit  lk_m0 [10];
        bit  lk_m1 [10];

        nil = '0;
        for (int i = 0; i < NumWords; i++) begin
            env_mem[i] = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem_rdata = '0;
        mem_ready = 1'b1;
        reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; m1_lock = 1'b0;
        m0_req = '0; m1_req = '0;
        mdl_last = 1; mdl_hold = 0; mdl_pv = 1'b0; mdl_pown = 0; mdl_perr = 1'b0;
        mdl_pdata = '0; mdl_pm0 = '0; mdl_pm1 = '0; mdl_pconf = '0;

        // Reset state
        step(1'b1, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk_en = 1'b1;
        step(1'b1, 1'b0, nil, 1'b0, nil, 1'b0, g);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk("rst_m0_ready", 32'(s_m0_ready), 32'd0);
        chk("rst_m0_rvalid", 32'(s_m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(s_m1_rvalid), 32'd0);
        chk("rst_m0_rdata", s_m0_rdata, 32'd0);
        chk("rst_mem_op", 32'(s_mem_op), 32'(MEM_NOP));

        // Single M0 store then load
        step(1'b0, 1'b1, mk(32'h10, 32'hDEAD_BEEF, MEM_SW), 1'b0, nil, 1'b0, g);
        chk("solo_sw_ready", 32'(s_m0_ready), 32'd1);
        step(1'b0, 1'b1, mk(32'h10, 32'h0, MEM_LW), 1'b0, nil, 1'b0, g);
        chk("solo_lw_ready", 32'(s_m0_ready), 32'd1);
        chk("solo_sw_ack", 32'(s_m0_rvalid), 32'd1);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk("solo_lw_rvalid", 32'(s_m0_rvalid), 32'd1);
        chk("solo_lw_rdata", s_m0_rdata, 32'hDEAD_BEEF);
        chk("solo_lw_err", 32'(s_m0_err), 32'd0);
        chk("solo_m1_rvalid", 32'(s_m1_rvalid), 32'd0);

        // Round-robin tie after reset: M0, M1, M0, M1
        step(1'b1, 1'b0, nil, 1'b0, nil, 1'b0, g);
        step(1'b0, 1'b1, mk(32'h20, 0, MEM_LW), 1'b1, mk(32'h30, 0, MEM_LW), 1'b0, g);
        chk("rr_g0", 32'(s_m0_ready), 32'd1);
        step(1'b0, 1'b1, mk(32'h24, 0, MEM_LW), 1'b1, mk(32'h30, 0, MEM_LW), 1'b0, g);
        chk("rr_g1", 32'(s_m1_ready), 32'd1);
        chk("rr_r0_owner", 32'(s_m0_rvalid), 32'd1);
        chk("rr_r0_data", s_m0_rdata, 32'h1000_0008);
        step(1'b0, 1'b1, mk(32'h24, 0, MEM_LW), 1'b1, mk(32'h34, 0, MEM_LW), 1'b0, g);
        chk("rr_g2", 32'(s_m0_ready), 32'd1);
        chk("rr_r1_owner", 32'(s_m1_rvalid), 32'd1);
        chk("rr_r1_data", s_m1_rdata, 32'h1000_000C);
        step(1'b0, 1'b1, mk(32'h28, 0, MEM_LW), 1'b1, mk(32'h34, 0, MEM_LW), 1'b0, g);
        chk("rr_g3", 32'(s_m1_ready), 32'd1);
        chk("rr_r2_owner", 32'(s_m0_rvalid), 32'd1);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk("rr_r3_owner", 32'(s_m1_rvalid), 32'd1);

        // Lock starvation bound
        step(1'b1, 1'b0, nil, 1'b0, nil, 1'b0, g);
        a = mk(32'h40, 0, MEM_LW);
        b = mk(32'h80, 0, MEM_LW);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, a, 1'b1, b, 1'b1, g);
            lk_m0[i] = s_m0_ready;
            lk_m1[i] = s_m1_ready;
            if (g == 0) a = mk(32'h44, 0, MEM_LW);
            if (g == 1) b = mk(b.addr + 32'd4, 0, MEM_LW);
        end
        for (int i = 0; i < 8; i++) chk("lock_m1_burst", 32'(lk_m1[i]), 32'd1);
        chk("lock_m0_turn", 32'(lk_m0[8]), 32'd1);
        chk("lock_m1_resume", 32'(lk_m1[9]), 32'd1);

        // Out-of-range store from M1 aliases word 0 in the BRAM
        step(1'b0, 1'b0, nil, 1'b1, mk(32'(MemBytes), 32'h1234_5678, MEM_SW), 1'b0, g);
        chk("oor_op_nop", 32'(s_mem_op), 32'(MEM_NOP));
        step(1'b0, 1'b0, nil, 1'b1, mk(32'h0, 0, MEM_LW), 1'b0, g);
        chk("oor_rvalid", 32'(s_m1_rvalid), 32'd1);
        chk("oor_err", 32'(s_m1_err), 32'd1);
        chk("oor_rdata", s_m1_rdata, 32'd0);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk("oor_mem_intact", s_m1_rdata, 32'h1000_0000);
        chk("oor_lw_err", 32'(s_m1_err), 32'd0);

        // Reset mid-operation
        step(1'b0, 1'b1, mk(32'h24, 0, MEM_LW), 1'b0, nil, 1'b0, g);
        chk("midrst_accept", 32'(s_m0_ready), 32'd1);
        step(1'b1, 1'b1, mk(32'h28, 0, MEM_LW), 1'b0, nil, 1'b0, g);
        chk("midrst_no_accept", 32'(s_m0_ready), 32'd0);
        step(1'b0, 1'b1, mk(32'h28, 0, MEM_LW), 1'b1, mk(32'h2C, 0, MEM_LW), 1'b0, g);
        chk("midrst_dropped", 32'(s_m0_rvalid), 32'd0);
        chk("midrst_m0_wins", 32'(s_m0_ready), 32'd1);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);

`ifdef RV32_MEM_ARB_PERF_EN
        // 3 conflict cycles then 2 solo M0 accepts
        step(1'b1, 1'b0, nil, 1'b0, nil, 1'b0, g);
        step(1'b0, 1'b1, mk(32'h50, 0, MEM_LW), 1'b1, mk(32'h60, 0, MEM_LW), 1'b0, g);
        step(1'b0, 1'b1, mk(32'h54, 0, MEM_LW), 1'b1, mk(32'h60, 0, MEM_LW), 1'b0, g);
        step(1'b0, 1'b1, mk(32'h54, 0, MEM_LW), 1'b1, mk(32'h64, 0, MEM_LW), 1'b0, g);
        step(1'b0, 1'b1, mk(32'h58, 0, MEM_LW), 1'b0, nil, 1'b0, g);
        step(1'b0, 1'b1, mk(32'h5C, 0, MEM_LW), 1'b0, nil, 1'b0, g);
        step(1'b0, 1'b0, nil, 1'b0, nil, 1'b0, g);
        chk("perf_conf_lit", s_perf_conf, 32'd3);
        chk("perf_m0_lit", s_perf_m0, 32'd4);
        chk("perf_m1_lit", s_perf_m1, 32'd1);
`endif

        // Randomized traffic; requesters hold each request until it is accepted.
        p0v = 1'b0; p1v = 1'b0; lk = 1'b0;
        p0r = nil; p1r = nil;
        for (int c = 0; c < 3000; c++) begin
            if (!p0v && $urandom_range(3, 0) != 0) begin
                p0v = 1'b1;
                p0r = rand_req();
            end
            if (!p1v && $urandom_range(3, 0) != 0) begin
                p1v = 1'b1;
                p1r = rand_req();
            end
            if ($urandom_range(15, 0) == 0) lk = !lk;
            rst = ($urandom_range(199, 0) == 0);
            step(rst, p0v, p0r, p1v, p1r, lk, g);
            if (g == 0) p0v = 1'b0;
            if (g == 1) p1v = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
